// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate modes, enable prescaler,
// terminal-count pulse, sticky overflow flag and zero-gated output.
module updown_mod_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               en,
  input  logic               dir,
  input  logic               mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               oe,
  input  logic               clr_ovf,
  output logic [WIDTH-1:0]   count_out,
  output logic               tc,
  output logic               ovf
);

  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   count_nxt;
  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] pcnt_nxt;
  logic               tc_nxt;
  logic               ovf_nxt;
  logic               tick_c;
  logic               at_bound_c;
  logic               boundary_c;
  logic [WIDTH-1:0]   load_clamp_c;

  // Tick qualification and boundary detection in the current direction
  always_comb begin
    tick_c       = en && (pcnt == presc_div);
    load_clamp_c = (load_val > limit) ? limit : load_val;
    at_bound_c   = dir ? (count >= limit) : (count == '0);
    boundary_c   = tick_c && !load && at_bound_c;
  end

  // Next-state: load > tick > hold; pcnt wraps naturally if presc_div drops below it
  always_comb begin
    count_nxt = count;
    pcnt_nxt  = pcnt;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;

    if (load) begin
      count_nxt = load_clamp_c;
      pcnt_nxt  = '0;
    end else begin
      if (en) begin
        pcnt_nxt = tick_c ? '0 : pcnt + PRESC_W'(1);
      end
      if (tick_c) begin
        if (dir) begin
          if (!at_bound_c) begin
            count_nxt = count + WIDTH'(1);
          end else if (!mode) begin
            count_nxt = '0;
          end
        end else begin
          if (!at_bound_c) begin
            count_nxt = count - WIDTH'(1);
          end else if (!mode) begin
            count_nxt = limit;
          end
        end
      end
    end

    tc_nxt = boundary_c;
    if (clr_ovf) begin
      ovf_nxt = 1'b0;
    end
    if (boundary_c) begin
      ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      pcnt  <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      pcnt  <= pcnt_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Output enable only gates the visible count, never the counting itself
  assign count_out = oe ? count : '0;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: a cycle model pushes expected state when
// stimulus is applied; entries are popped and compared one edge later.
module tb_updown_mod_counter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic               en;
  logic               dir;
  logic               mode;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc_div;
  logic               oe;
  logic               clr_ovf;
  logic [WIDTH-1:0]   count_out;
  logic               tc;
  logic               ovf;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    bit oe;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt, m_pcnt;
  bit   m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  updown_mod_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
    .dir(dir), .mode(mode), .limit(limit), .presc_div(presc_div), .oe(oe),
    .clr_ovf(clr_ovf), .count_out(count_out), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input int val);
    check_eq(tag, 32'(count_out), 32'(val));
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_pcnt = 0;
    m_ovf  = 1'b0;
  endtask

  // Apply one clock with the currently driven inputs, then score the result
  task automatic cyc();
    exp_t e;
    exp_t o;
    int   ncnt, npc;
    bit   tick, bnd;
    tick = en && (m_pcnt == int'(presc_div));
    ncnt = m_cnt;
    npc  = m_pcnt;
    bnd  = 1'b0;
    if (load) begin
      ncnt = (int'(load_val) > int'(limit)) ? int'(limit) : int'(load_val);
      npc  = 0;
    end else begin
      if (en) npc = tick ? 0 : (m_pcnt + 1) % (1 << PRESC_W);
      if (tick) begin
        if (dir) begin
          if (m_cnt < int'(limit)) ncnt = m_cnt + 1;
          else begin bnd = 1'b1; if (!mode) ncnt = 0; end
        end else begin
          if (m_cnt > 0) ncnt = m_cnt - 1;
          else begin bnd = 1'b1; if (!mode) ncnt = int'(limit); end
        end
      end
    end
    if (clr_ovf) m_ovf = 1'b0;
    if (bnd) m_ovf = 1'b1;
    m_cnt  = ncnt;
    m_pcnt = npc;
    e.cnt = ncnt; e.tc = bnd; e.ovf = m_ovf; e.oe = oe;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'(0), 32'(1));
    end else begin
      o = exp_q.pop_front();
      check_eq("count_out", 32'(count_out), o.oe ? 32'(o.cnt) : 32'(0));
      check_eq("tc", 32'(tc), 32'(o.tc));
      check_eq("ovf", 32'(ovf), 32'(o.ovf));
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b1; mode = 1'b0;
    limit = 8'd255; presc_div = '0; oe = 1'b1; clr_ovf = 1'b0;
    model_reset();
    #3;
    expect_out("reset_count", 0);
    check_eq("reset_tc", 32'(tc), 32'(0));
    check_eq("reset_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Up-count and wrap
    en = 1'b1; load = 1'b1; load_val = 8'd254;
    cyc(); expect_out("t1_load", 254);
    load = 1'b0;
    cyc(); expect_out("t1_255", 255);
    cyc(); expect_out("t1_wrap", 0);
    check_eq("t1_tc", 32'(tc), 32'(1));
    check_eq("t1_ovf", 32'(ovf), 32'(1));
    cyc(); check_eq("t1_ovf_sticky", 32'(ovf), 32'(1));
    clr_ovf = 1'b1;
    cyc(); check_eq("t1_clr", 32'(ovf), 32'(0));
    clr_ovf = 1'b0;

    // Down-count wrap to limit
    limit = 8'd9; dir = 1'b0; load = 1'b1; load_val = 8'd1;
    cyc(); load = 1'b0;
    cyc(); expect_out("t2_zero", 0);
    cyc(); expect_out("t2_wrap", 9);
    check_eq("t2_tc", 32'(tc), 32'(1));
    cyc(); expect_out("t2_8", 8);

    // Saturate
    mode = 1'b1; dir = 1'b1; limit = 8'd255; load = 1'b1; load_val = 8'd253;
    cyc(); load = 1'b0;
    cycles(2); expect_out("t3_255", 255);
    cyc(); check_eq("t3_tc_hold1", 32'(tc), 32'(1));
    cyc(); check_eq("t3_tc_hold2", 32'(tc), 32'(1));
    expect_out("t3_sat", 255);
    dir = 1'b0;
    cyc(); expect_out("t3_down", 254);

    // Prescaler with enable gap
    mode = 1'b0; dir = 1'b1; presc_div = 8'd3; load = 1'b1; load_val = 8'd0;
    cyc(); load = 1'b0;
    cycles(3); expect_out("t4_no_step", 0);
    cyc(); expect_out("t4_step", 1);
    cycles(2);
    en = 1'b0; cycles(5); expect_out("t4_hold", 1);
    en = 1'b1; cyc(); expect_out("t4_resume", 1);
    cyc(); expect_out("t4_step2", 2);

    // Load on a tick cycle, clamped to limit
    cycles(3);
    limit = 8'd15; load = 1'b1; load_val = 8'd20;
    cyc(); expect_out("t5_clamp", 15);
    check_eq("t5_tc_supp", 32'(tc), 32'(0));
    load = 1'b0; limit = 8'd5;
    cycles(3); expect_out("t5_wait", 15);
    cyc(); expect_out("t5_over_limit_wrap", 0);
    check_eq("t5_tc", 32'(tc), 32'(1));
    presc_div = '0; limit = 8'd15; load = 1'b1; load_val = 8'd15;
    cyc(); load = 1'b0; limit = 8'd5; dir = 1'b0;
    cyc(); expect_out("t5_down_normal", 14);

    // presc_div lowered below pcnt: pcnt runs to full scale and wraps
    dir = 1'b1; limit = 8'd255; presc_div = 8'd3; load = 1'b1; load_val = 8'd0;
    cyc(); load = 1'b0;
    cycles(2); presc_div = 8'd1;
    cycles(260);

    // Output gating, set-wins, async reset
    presc_div = '0; oe = 1'b0; clr_ovf = 1'b1; load = 1'b1; load_val = 8'd0;
    cyc(); load = 1'b0;
    cycles(10); expect_out("t6_gated", 0);
    oe = 1'b1; #1; expect_out("t6_oe_comb", 10);
    limit = 8'd10;
    cyc(); check_eq("t6_set_wins", 32'(ovf), 32'(1));
    clr_ovf = 1'b0; dir = 1'b0;
    cyc(); expect_out("t6_pre_reset", 10);
    #2; rst_n = 1'b0; #1;
    model_reset();
    expect_out("t6_rst_count", 0);
    check_eq("t6_rst_tc", 32'(tc), 32'(0));
    check_eq("t6_rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1; dir = 1'b1; limit = 8'd255;
    cyc(); expect_out("t6_first_tick", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised successor to the team's 8-bit loadable counter. Adds:
- configurable width;
- up/down direction;
- programmable modulus (limit);
- wrap or saturate mode;
- enable prescaler;
- terminal-count pulse and sticky overflow flag;
- zero-gated output enable.

It sits behind the TinyTapeout top-level pin mux, which drives its controls from `ui_in`/`uio_in` and routes `count_out` to `uo_out`.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `PRESC_W`, default 8: prescaler divider width in bits.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: value to load.
- `en` in 1: count enable, which gates the prescaler.
- `dir` in 1: 1 = up, 0 = down.
- `mode` in 1: 0 = wrap, 1 = saturate.
- `limit` in WIDTH: upper bound; the count range is 0..limit.
- `presc_div` in PRESC_W: one count step per `presc_div`+1 enabled cycles.
- `oe` in 1: output enable.
- `clr_ovf` in 1: clears the sticky overflow flag.
- `count_out` out WIDTH: `oe` ? count : 0.
- `tc` out 1: terminal-count pulse, registered.
- `ovf` out 1: sticky boundary flag, registered.

## Operation
**Reset (asynchronous).** `rst_n`=0 forces `count`=0, prescaler `pcnt`=0, `tc`=0, `ovf`=0. `count_out`=0 regardless of `oe`.

**Prescaler.**
- When `en`=1: if `pcnt`==`presc_div`, then `tick`=1 and `pcnt`←0; otherwise `pcnt`←`pcnt`+1.
- When `en`=0: `pcnt` holds and there is no tick.
- `presc_div`=0 gives a tick on every enabled cycle.

**Step priority per clock edge:** load > tick > hold.
- **Load:** `count`←min(`load_val`, `limit`) and `pcnt`←0. Load suppresses any tick, `tc` and `ovf` set in that cycle.
- **Tick, up (`dir`=1):**
  - if `count` < `limit`: `count`+1;
  - else (boundary): wrap mode `count`←0, saturate mode `count` holds.
- **Tick, down (`dir`=0):**
  - if `count` > 0: `count`−1;
  - else (boundary): wrap mode `count`←`limit`, saturate mode `count` holds.

**Boundary events.** A boundary event is a tick taken at the boundary in the current direction.
- `tc` is 1 in the cycle after a boundary event and 0 otherwise. It re-pulses on every boundary tick, including repeated ticks while saturated.
- `ovf` is set on a boundary event and cleared by `clr_ovf`. If a set and `clr_ovf` occur in the same cycle, set wins.

**Limit changes.**
- `limit` lowered below the current `count`: the next up tick is a boundary event; the next down tick decrements normally.
- `limit`=0: every tick is a boundary event and `count` stays 0.

**Live controls.** `dir`, `mode`, `limit` and `presc_div` are sampled every cycle with no shadowing. A change takes effect on the next tick. If `presc_div` is lowered below `pcnt`, `pcnt` counts up to its full-scale value and wraps to 0. It does not lock up.

**Output gating.** `oe` only gates `count_out`. Counting continues while `oe`=0. `count_out` is zero-gated and never high-Z.

**Arithmetic.** All counter arithmetic is unsigned, modulo 2^WIDTH. Internally there is no out-of-range state.

## Timing
- `count` updates on the rising `clk` edge following the sampled tick or load. Latency from `load` to `count_out` is 1 cycle.
- `tc` and `ovf` are registered. They assert on the same edge that shows the wrapped or saturated `count`.
- `count_out` follows `oe` combinationally, with zero latency.
- Throughput: at most one step per `presc_div`+1 enabled cycles.
- Reset deassertion: the first tick can occur on the first edge with `en`=1 (`presc_div`=0).
- Reset assertion mid-count: everything clears immediately, without waiting for a clock edge. Any pending tick is lost.

## Test plan
- **Basic up-count and wrap.** WIDTH=8, `limit`=255, `presc_div`=0, `en`=1, `dir`=1, `mode`=0; load 254.
  - Expect `count` 254 → 255 → 0.
  - `tc`=1 only in the cycle showing 0; `ovf`=1 and stays 1.
  - Pulse `clr_ovf` → `ovf`=0.
- **Down-count wrap to limit.** `limit`=9, `dir`=0, load 1.
  - Expect 1 → 0 → 9 → 8; `tc` pulses once, with the 9.
- **Saturate mode.** `mode`=1, `dir`=1, `limit`=255, load 253.
  - Expect 254, 255, 255, 255; `tc` is 1 on each of the two held cycles.
  - Switch `dir`=0 → 254.
- **Prescaler.** `presc_div`=3.
  - Expect `count` to advance once per 4 enabled cycles.
  - Deassert `en` for 5 cycles mid-period: `count` and phase hold. Resume: the remaining cycles of the period complete before the next step.
- **Load priority and clamping.** `load`=1 with `load_val`=20, `limit`=15, on a cycle that would tick.
  - Expect `count`=15, `tc`=0, and the next tick after 4 cycles with `presc_div`=3.
  - Lower `limit` to 5 while `count`=15, then tick up → 0 with `tc`.
- **Output gating and reset.** `oe`=0 while counting from 0 for 10 ticks.
  - `count_out`=0 throughout. Raise `oe` → `count_out`=10 in the same cycle.
  - Set `ovf` and `clr_ovf` in the same cycle → `ovf`=1.
  - Assert `rst_n`=0 between clock edges → `count_out`, `tc` and `ovf` go to 0 immediately.
